// File: rtl/alu_seq.sv
// Registered, parametrised ALU with valid/ready operand handshake and error flag.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add unsigned multiply (opcode 10).
module alu_seq #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         opcode,
   input  logic [WIDTH-1:0]   p1,
   input  logic [WIDTH-1:0]   p2,
   output logic               out_valid,
   output logic [WIDTH-1:0]   result,
   output logic               z,
   output logic               n,
   output logic               ov,
   output logic               err
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_SLL = 4'd5;
   localparam logic [3:0] OP_SRL = 4'd6;
   localparam logic [3:0] OP_SRA = 4'd7;
   localparam logic [3:0] OP_LL  = 4'd8;
   localparam logic [3:0] OP_LH  = 4'd9;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd10;
`endif

   localparam int HALF = WIDTH / 2;

   logic [WIDTH-1:0]   r_result;
   logic               r_ov;
   logic               r_err;
   logic               r_out_valid;

   logic               w_accept;
   logic               w_start_mul;
   logic [WIDTH-1:0]   w_res;
   logic               w_ov;
   logic               w_err;
   logic [WIDTH-1:0]   w_sum;
   logic [WIDTH-1:0]   w_diff;
   logic [SHAMT_W-1:0] w_shamt;

`ifdef ALU_SEQ_MUL_EN
   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_BUSY  = 1'b1;
   localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(WIDTH - 1);

   logic [0:0]         r_state;
   logic [SHAMT_W:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] w_acc_next;

   assign in_ready   = ~rst & (r_state == ST_IDLE);
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`else
   assign in_ready   = ~rst;
`endif

   assign w_accept = in_valid & in_ready;
   assign w_sum    = p1 + p2;
   assign w_diff   = p1 - p2;
   assign w_shamt  = p2[SHAMT_W-1:0];

   always_comb begin
      w_res       = '0;
      w_ov        = 1'b0;
      w_err       = 1'b0;
      w_start_mul = 1'b0;
      case (opcode)
         OP_ADD: begin
            w_res = w_sum;
            w_ov  = (p1[WIDTH-1] == p2[WIDTH-1]) && (w_sum[WIDTH-1] != p1[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_diff;
            w_ov  = (p1[WIDTH-1] != p2[WIDTH-1]) && (w_diff[WIDTH-1] != p1[WIDTH-1]);
         end
         OP_XOR: w_res = p1 ^ p2;
         OP_AND: w_res = p1 & p2;
         OP_OR:  w_res = p1 | p2;
         OP_SLL: w_res = p1 << w_shamt;
         OP_SRL: w_res = p1 >> w_shamt;
         OP_SRA: w_res = $signed(p1) >>> w_shamt;
         OP_LL:  w_res = {{HALF{1'b0}}, p1[HALF-1:0]};
         OP_LH:  w_res = {p1[HALF-1:0], p2[HALF-1:0]};
`ifdef ALU_SEQ_MUL_EN
         OP_MUL: w_start_mul = 1'b1;
`endif
         default: w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result    <= '0;
         r_ov        <= 1'b0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
`endif
      end else begin
         r_out_valid <= 1'b0;
         if (w_accept && !w_start_mul) begin
            r_result    <= w_res;
            r_ov        <= w_ov;
            r_err       <= w_err;
            r_out_valid <= 1'b1;
         end
`ifdef ALU_SEQ_MUL_EN
         case (r_state)
            ST_IDLE: begin
               if (w_accept && w_start_mul) begin
                  r_state  <= ST_BUSY;
                  r_cnt    <= '0;
                  r_acc    <= '0;
                  r_mcand  <= {{WIDTH{1'b0}}, p1};
                  r_mplier <= p2;
               end
            end
            default: begin
               // Step WIDTH-1 -> WIDTH completes; the final partial sum feeds the result directly.
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state     <= ST_IDLE;
                  r_result    <= w_acc_next[WIDTH-1:0];
                  r_ov        <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_err       <= 1'b0;
                  r_out_valid <= 1'b1;
               end
            end
         endcase
`endif
      end
   end

   assign result    = r_result;
   assign z         = (r_result == '0);
   assign n         = r_result[WIDTH-1];
   assign ov        = r_ov;
   assign err       = r_err;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus a randomized stream
// checked against an arithmetic reference model.
module tb_alu_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   opcode;
   logic [W-1:0] p1;
   logic [W-1:0] p2;
   logic         out_valid;
   logic [W-1:0] result;
   logic         z;
   logic         n;
   logic         ov;
   logic         err;

   int vectors    = 0;
   int miscompares = 0;

   // observed/expected packed as {out_valid, err, ov, n, z, result}
   logic [W+4:0] obs;
   logic [W+4:0] exp_v;
   logic [W+4:0] last_exp;

`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   alu_seq #(.WIDTH(W), .SHAMT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .p1        (p1),
      .p2        (p2),
      .out_valid (out_valid),
      .result    (result),
      .z         (z),
      .n         (n),
      .ov        (ov),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference computed with plain integer arithmetic on signed/unsigned values.
   function automatic logic [W+4:0] ref_alu(input int op, input int a, input int b);
      int     sa, sb, t, sh, res;
      longint prod;
      bit     f_ov, f_err;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      sh = b % 16;
      res = 0; f_ov = 1'b0; f_err = 1'b0;
      case (op)
         0: begin t = sa + sb; f_ov = (t > 32767) || (t < -32768); res = (a + b) % 65536; end
         1: begin t = sa - sb; f_ov = (t > 32767) || (t < -32768); res = (a - b + 65536) % 65536; end
         2: res = a ^ b;
         3: res = a & b;
         4: res = a | b;
         5: res = (a * (1 << sh)) % 65536;
         6: res = a / (1 << sh);
         7: res = (sa >>> sh) & 65535;
         8: res = a % 256;
         9: res = (a % 256) * 256 + (b % 256);
         10: begin
            if (MUL_EN) begin
               prod = longint'(a) * longint'(b);
               res  = int'(prod % 65536);
               f_ov = prod >= 65536;
            end else f_err = 1'b1;
         end
         default: f_err = 1'b1;
      endcase
      return {1'b1, f_err, f_ov, res[15], (res == 0), res[15:0]};
   endfunction

   task automatic drive(input int op, input int a, input int b);
      in_valid = 1'b1;
      opcode   = op[3:0];
      p1       = a[W-1:0];
      p2       = b[W-1:0];
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(0, 16'h1234, 16'h1111);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      obs = {out_valid, err, ov, n, z, result};
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL reset_state got %h expected %h", obs, exp_v);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready got %b expected 1", in_ready);
      end
      @(posedge clk); #1;
      last_exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
   endtask

   task automatic test_directed;
      int ops[6]  = '{0, 1, 7, 6, 9, 8};
      int as_[6]  = '{16'h7FFF, 16'h0005, 16'h8000, 16'h8000, 16'h12AB, 16'h12AB};
      int bs_[6]  = '{16'h0001, 16'h0005, 16'h0004, 16'h0004, 16'h34CD, 16'h0000};
      logic [W+4:0] fixed[6];
      fixed[0] = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8000};
      fixed[1] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      fixed[2] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF800};
      fixed[3] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0800};
      fixed[4] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hABCD};
      fixed[5] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00AB};
      for (int i = 0; i < 6; i++) begin
         drive(ops[i], as_[i], bs_[i]);
         @(posedge clk); #1;
         vectors++;
         obs = {out_valid, err, ov, n, z, result};
         if (obs !== fixed[i]) begin
            miscompares++;
            $display("FAIL directed_%0d op=%0d got %h expected %h", i, ops[i], obs, fixed[i]);
         end
      end
      in_valid = 1'b0;
      last_exp = fixed[5];
   endtask

   task automatic test_illegal;
      int ops[3] = '{12, 10, 0};
      for (int i = 0; i < 3; i++) begin
         if (ops[i] == 10 && MUL_EN) continue;
         drive(ops[i], 16'h00F0, 16'h0001);
         @(posedge clk); #1;
         vectors++;
         obs = {out_valid, err, ov, n, z, result};
         exp_v = ref_alu(ops[i], 16'h00F0, 16'h0001);
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL illegal_seq_op%0d got %h expected %h", ops[i], obs, exp_v);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      vectors++;
      obs = {out_valid, err, ov, n, z, result};
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00F1};
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL idle_hold got %h expected %h", obs, exp_v);
      end
      last_exp = exp_v;
   endtask

   task automatic test_back_to_back;
      int op, a, b;
      bit gap;
      for (int i = 0; i < 300; i++) begin
         gap = ($urandom_range(0, 7) == 0);
         op  = $urandom_range(0, 15);
         if (MUL_EN && op == 10) op = 2;
         a = $urandom_range(0, 65535);
         b = $urandom_range(0, 65535);
         if (gap) in_valid = 1'b0;
         else drive(op, a, b);
         @(posedge clk); #1;
         if (gap) exp_v = {1'b0, last_exp[W+3:0]};
         else exp_v = ref_alu(op, a, b);
         last_exp = exp_v;
         vectors++;
         obs = {out_valid, err, ov, n, z, result};
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL stream_%0d op=%0d a=%h b=%h got %h expected %h", i, op, a, b, obs, exp_v);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      last_exp = {1'b0, last_exp[W+3:0]};
   endtask

`ifdef ALU_SEQ_MUL_EN
   task automatic mul_once(input int a, input int b, input string tag);
      drive(10, a, b);
      @(posedge clk); #1;
      drive(0, 16'h0001, 16'h0001);
      exp_v = ref_alu(10, a, b);
      for (int k = 0; k < 16; k++) begin
         if (k == 4) in_valid = 1'b0;
         vectors++;
         if (out_valid !== 1'b0 || (k < 15 && in_ready !== 1'b0)) begin
            miscompares++;
            $display("FAIL %s busy_cycle_%0d out_valid=%b in_ready=%b expected 0/0", tag, k, out_valid, in_ready);
         end
         @(posedge clk); #1;
      end
      vectors++;
      obs = {out_valid, err, ov, n, z, result};
      if (obs !== exp_v || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s done got %h ready=%b expected %h ready=1", tag, obs, in_ready, exp_v);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s out_valid_pulse got %b expected 0", tag, out_valid);
      end
   endtask

   task automatic test_mul;
      mul_once(16'h0012, 16'h0034, "mul_small");
      mul_once(16'h0100, 16'h0100, "mul_ovf");
      for (int i = 0; i < 6; i++)
         mul_once($urandom_range(0, 65535), $urandom_range(0, 65535), "mul_rand");
   endtask

   task automatic test_reset_mid_mul;
      int seen;
      drive(10, 16'h0012, 16'h0034);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      vectors++;
      obs = {out_valid, err, ov, n, z, result};
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      if (obs !== exp_v || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_mul_reset got %h ready=%b expected %h ready=1", obs, in_ready, exp_v);
      end
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL aborted_mul_out_valid got %0d pulses expected 0", seen);
      end
      drive(0, 16'h0001, 16'h0001);
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      obs = {out_valid, err, ov, n, z, result};
      exp_v = ref_alu(0, 1, 1);
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL add_after_abort got %h expected %h", obs, exp_v);
      end
   endtask
`endif

   initial begin
      in_valid = 1'b0;
      opcode   = '0;
      p1       = '0;
      p2       = '0;
      test_reset;
      test_directed;
      test_illegal;
      test_back_to_back;
`ifdef ALU_SEQ_MUL_EN
      test_mul;
      test_reset_mid_mul;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
